// File: rtl/ethernet_rx_initiator.sv
// Bus initiator that drains received Ethernet packets from the controller slave port onto a valid/ready stream.
// Optional build macro ETH_RX_INITIATOR_TIMEOUT_EN adds a 1024-cycle watchdog on every bus state.
module ethernet_rx_initiator #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 14,
  parameter int eth_mtu_p = 2048,
  parameter logic [addr_width_p-1:0] rx_data_base_p = 14'h0000,
  parameter logic [addr_width_p-1:0] rx_size_addr_p = 14'h1004,
  parameter logic [addr_width_p-1:0] rx_ack_addr_p = 14'h1010,
  parameter int holdoff_p = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic start_i,
  output logic busy_o,
  output logic error_o,
  output logic [addr_width_p-1:0] addr_o,
  output logic write_en_o,
  output logic read_en_o,
  input  logic ready_and_i,
  output logic [$clog2($clog2(data_width_p/8)+1)-1:0] op_size_o,
  output logic [data_width_p-1:0] write_data_o,
  input  logic valid_i,
  output logic ready_and_o,
  input  logic [data_width_p-1:0] read_data_i,
  output logic [data_width_p-1:0] data_o,
  output logic [data_width_p/8-1:0] keep_o,
  output logic v_o,
  output logic last_o,
  input  logic yumi_i
);

  localparam int bytes_lp = data_width_p / 8;
  localparam int lg_bytes_lp = $clog2(bytes_lp);
  localparam int op_width_lp = $clog2(lg_bytes_lp + 1);
  localparam int hold_width_lp = (holdoff_p > 1) ? $clog2(holdoff_p) : 1;
  localparam logic [op_width_lp-1:0] op_full_lp = op_width_lp'(lg_bytes_lp);
  localparam logic [addr_width_p-1:0] stride_lp = addr_width_p'(bytes_lp);
  localparam logic [hold_width_lp-1:0] hold_last_lp = hold_width_lp'(holdoff_p - 1);
  localparam logic [31:0] mtu_lp = 32'(eth_mtu_p);
  localparam logic [bytes_lp-1:0] keep_one_lp = bytes_lp'(1);

  typedef enum logic [2:0] {
    IDLE, SIZE_REQ, SIZE_RSP, DATA_REQ, DATA_RSP, ACK_REQ, ACK_RSP, HOLD
  } state_e;

  state_e state_reg, state_next;

  logic [addr_width_p-1:0] addr_reg;
  logic [11:0] words_left_reg;
  logic [lg_bytes_lp-1:0] rem_reg;
  logic [hold_width_lp-1:0] hold_cnt_reg;
  logic error_reg;
  logic v_reg;
  logic last_reg;
  logic [bytes_lp-1:0] keep_reg;
  logic [data_width_p-1:0] data_reg;

  logic [11:0] size_w;
  logic size_bad;
  logic [12:0] size_round;
  logic [bytes_lp-1:0] keep_last;
  logic size_err;
  logic abort;
  logic wd_expired;
  logic in_bus;
  logic size_take;
  logic data_take;

  assign size_w = read_data_i[11:0];
  assign size_bad = (size_w == 12'd0) || ({20'd0, size_w} > mtu_lp);
  assign size_round = {1'b0, size_w} + 13'(bytes_lp - 1);
  // A zero remainder means the final word is completely filled.
  assign keep_last = (rem_reg == '0) ? '1 : ((keep_one_lp << rem_reg) - keep_one_lp);
  assign in_bus = (state_reg != IDLE) && (state_reg != HOLD);
  assign size_take = (state_reg == SIZE_RSP) && valid_i && ready_and_o;
  assign data_take = (state_reg == DATA_RSP) && valid_i && ready_and_o;

  assign error_o = error_reg;
  assign v_o = v_reg;
  assign last_o = last_reg;
  assign keep_o = keep_reg;
  assign data_o = data_reg;

`ifdef ETH_RX_INITIATOR_TIMEOUT_EN
  logic [9:0] wd_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wd_reg <= '0;
    end else if (state_next != state_reg) begin
      wd_reg <= '0;
    end else begin
      wd_reg <= wd_reg + 10'd1;
    end
  end

  assign wd_expired = (wd_reg == 10'h3ff);
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy_o = (state_reg != IDLE);
    addr_o = '0;
    write_en_o = 1'b0;
    read_en_o = 1'b0;
    op_size_o = '0;
    write_data_o = '0;
    ready_and_o = 1'b0;
    size_err = 1'b0;
    abort = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) state_next = SIZE_REQ;
      end
      SIZE_REQ: begin
        read_en_o = 1'b1;
        addr_o = rx_size_addr_p;
        op_size_o = op_full_lp;
        if (ready_and_i) state_next = SIZE_RSP;
      end
      SIZE_RSP: begin
        ready_and_o = 1'b1;
        if (valid_i) begin
          if (size_bad) begin
            size_err = 1'b1;
            state_next = ACK_REQ;
          end else begin
            state_next = DATA_REQ;
          end
        end
      end
      DATA_REQ: begin
        read_en_o = 1'b1;
        addr_o = addr_reg;
        op_size_o = op_full_lp;
        if (ready_and_i) state_next = DATA_RSP;
      end
      DATA_RSP: begin
        // One-entry output register: accept only when it is empty or being drained.
        ready_and_o = ~v_reg | yumi_i;
        if (valid_i && ready_and_o) begin
          state_next = (words_left_reg == 12'd1) ? ACK_REQ : DATA_REQ;
        end
      end
      ACK_REQ: begin
        if (!v_reg) begin
          write_en_o = 1'b1;
          addr_o = rx_ack_addr_p;
          op_size_o = op_full_lp;
          write_data_o = data_width_p'(1);
          if (ready_and_i) state_next = ACK_RSP;
        end
      end
      ACK_RSP: begin
        ready_and_o = 1'b1;
        if (valid_i) state_next = HOLD;
      end
      HOLD: begin
        if (hold_cnt_reg == hold_last_lp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A handshake completing in the expiry cycle wins over the watchdog.
    if (wd_expired && in_bus && (state_next == state_reg)) begin
      abort = 1'b1;
      state_next = HOLD;
      addr_o = '0;
      write_en_o = 1'b0;
      read_en_o = 1'b0;
      op_size_o = '0;
      write_data_o = '0;
      ready_and_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_reg <= '0;
      words_left_reg <= '0;
      rem_reg <= '0;
      hold_cnt_reg <= '0;
      error_reg <= 1'b0;
      v_reg <= 1'b0;
      last_reg <= 1'b0;
      keep_reg <= '0;
      data_reg <= '0;
    end else begin
      error_reg <= size_err | abort;
      hold_cnt_reg <= (state_reg == HOLD) ? hold_cnt_reg + hold_width_lp'(1) : '0;

      if (size_take && !size_bad) begin
        words_left_reg <= 12'(size_round >> lg_bytes_lp);
        rem_reg <= size_w[lg_bytes_lp-1:0];
        addr_reg <= rx_data_base_p;
      end

      if (abort) begin
        v_reg <= 1'b0;
        last_reg <= 1'b0;
        keep_reg <= '0;
        data_reg <= '0;
      end else if (data_take) begin
        data_reg <= read_data_i;
        v_reg <= 1'b1;
        last_reg <= (words_left_reg == 12'd1);
        keep_reg <= (words_left_reg == 12'd1) ? keep_last : '1;
        addr_reg <= addr_reg + stride_lp;
        words_left_reg <= words_left_reg - 12'd1;
      end else if (yumi_i) begin
        v_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ethernet_rx_initiator.sv
// Self-checking bench for ethernet_rx_initiator: slave/consumer models plus a packet-level reference model.
module tb_ethernet_rx_initiator;
  localparam int HOLDOFF = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic ready_and_in = 1'b0;
  logic valid_in = 1'b0;
  logic yumi = 1'b0;
  logic [31:0] read_data = '0;
  logic busy, error, write_en, read_en, ready_and_out, v, last;
  logic [13:0] addr;
  logic [1:0] op_size;
  logic [31:0] write_data, data;
  logic [3:0] keep;

  ethernet_rx_initiator dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .busy_o(busy), .error_o(error),
    .addr_o(addr), .write_en_o(write_en), .read_en_o(read_en), .ready_and_i(ready_and_in),
    .op_size_o(op_size), .write_data_o(write_data), .valid_i(valid_in),
    .ready_and_o(ready_and_out), .read_data_i(read_data), .data_o(data), .keep_o(keep),
    .v_o(v), .last_o(last), .yumi_i(yumi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] a;
    logic we;
    logic [31:0] wd;
    logic [1:0] op;
  } req_t;
  typedef struct {
    logic [31:0] d;
    logic [3:0] k;
    logic l;
  } beat_t;
  typedef struct {
    int size;
    int pct;
    int s_at;
    int s_len;
    int exp_words;
    logic [3:0] exp_keep;
    int exp_err;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // slave and consumer model state
  bit pending = 0;
  bit no_valid = 0;
  int delay = 0;
  logic [31:0] rsp_data = '0;
  logic [11:0] size_reg = '0;
  logic [31:0] mem [512];
  int yumi_pct = 100;
  int stall_at = 0, stall_len = 0, stall_left = 0, words_seen = 0;

  // observation logs
  req_t req_q[$];
  beat_t beat_q[$];
  int err_pulses = 0, inv_bad = 0, v_cnt = 0, hold_n = 0, idle_n = 0;
  bit ack_req_out = 0, ack_fired = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [31:0] lookup(input logic [13:0] a, input logic w);
    logic [19:0] junk;
    junk = 20'($urandom);
    if (w) return 32'd0;
    if (a == 14'h1004) return {junk, size_reg};
    if (a < 14'h0800) return mem[a[10:2]];
    return 32'hdead_beef;
  endfunction

  // One clock: drive inputs at the falling edge, observe what the next rising edge will accept.
  task automatic tick();
    req_t r;
    beat_t b;
    @(negedge clk);
    valid_in = pending && (delay == 0) && !no_valid;
    read_data = valid_in ? rsp_data : $urandom;
    ready_and_in = !pending && ($urandom_range(0, 3) != 0);
    if (stall_left > 0) begin
      yumi = 1'b0;
      stall_left--;
    end else begin
      yumi = v && ($urandom_range(0, 99) < yumi_pct);
    end
    #1;
    if (error) err_pulses++;
    if (v) v_cnt++;
    if (v && !yumi && ready_and_out) inv_bad++;
    if (write_en && v) inv_bad++;
    if (valid_in && ready_and_out) begin
      pending = 0;
      if (ack_req_out) ack_fired = 1;
      ack_req_out = 0;
    end
    if ((read_en || write_en) && ready_and_in) begin
      r.a = addr; r.we = write_en; r.wd = write_data; r.op = op_size;
      req_q.push_back(r);
      pending = 1;
      delay = $urandom_range(0, 2);
      rsp_data = lookup(addr, write_en);
      ack_req_out = write_en;
    end else if (pending && !valid_in && delay > 0) begin
      delay--;
    end
    if (v && yumi) begin
      b.d = data; b.k = keep; b.l = last;
      beat_q.push_back(b);
      words_seen++;
      if (words_seen == stall_at) stall_left = stall_len;
    end
  endtask

  function automatic int outs_ones();
    return $countones({busy, error, write_en, read_en, ready_and_out, v, last, keep, data,
                       addr, op_size, write_data});
  endfunction

  task automatic prep(input int size, input int pct, input int s_at, input int s_len);
    size_reg = size[11:0];
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    req_q.delete();
    beat_q.delete();
    err_pulses = 0; inv_bad = 0; v_cnt = 0; words_seen = 0;
    yumi_pct = pct; stall_at = s_at; stall_len = s_len; stall_left = 0;
    ack_fired = 0; ack_req_out = 0;
  endtask

  // Reference: what a packet of this size must produce, computed from the packet rules alone.
  task automatic model_check(input int size, input string tag);
    bit bad;
    int nw, rbad, sbad, rem;
    req_t e;
    req_t exp_q[$];
    logic [3:0] ek;
    bad = (size == 0) || (size > 2048);
    nw = bad ? 0 : (size + 3) / 4;
    rem = size % 4;
    e.a = 14'h1004; e.we = 0; e.wd = 0; e.op = 2'd2;
    exp_q.push_back(e);
    for (int i = 0; i < nw; i++) begin
      e.a = 14'(i * 4);
      exp_q.push_back(e);
    end
    e.a = 14'h1010; e.we = 1; e.wd = 32'd1;
    exp_q.push_back(e);
    rbad = 0;
    for (int i = 0; i < exp_q.size() && i < req_q.size(); i++) begin
      if (req_q[i].a !== exp_q[i].a || req_q[i].we !== exp_q[i].we || req_q[i].op !== exp_q[i].op ||
          (exp_q[i].we && req_q[i].wd !== exp_q[i].wd)) rbad++;
    end
    sbad = 0;
    for (int i = 0; i < nw && i < beat_q.size(); i++) begin
      ek = (i == nw - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hf;
      if (beat_q[i].d !== mem[i] || beat_q[i].k !== ek || beat_q[i].l !== (i == nw - 1)) sbad++;
    end
    check({tag, "_nreq"}, req_q.size(), exp_q.size());
    check({tag, "_reqseq_bad"}, rbad, 0);
    check({tag, "_nbeats"}, beat_q.size(), nw);
    check({tag, "_stream_bad"}, sbad, 0);
    check({tag, "_err_pulses"}, err_pulses, bad ? 1 : 0);
    check({tag, "_handshake_bad"}, inv_bad, 0);
    check({tag, "_v_seen"}, v_cnt > 0, nw > 0);
    check({tag, "_hold"}, hold_n, HOLDOFF);
    $display("pkt %s size=%0d reqs=%0d beats=%0d err_pulses=%0d hold=%0d",
             tag, size, req_q.size(), beat_q.size(), err_pulses, hold_n);
  endtask

  task automatic run_packet(input int size, input int pct, input int s_at, input int s_len,
                            input bit hold_start, input string tag);
    int n;
    prep(size, pct, s_at, s_len);
    start = 1'b1;
    idle_n = 0;
    tick();
    while (!busy && idle_n < 20) begin
      idle_n++;
      tick();
    end
    if (!hold_start) start = 1'b0;
    n = 0;
    while (!ack_fired && n < 30000) begin
      tick();
      n++;
    end
    check({tag, "_ack_seen"}, ack_fired, 1);
    hold_n = 0;
    while (busy && hold_n < 100) begin
      tick();
      if (busy) hold_n++;
    end
    model_check(size, tag);
  endtask

  vec_t vecs[9];
  int rs;
  int n;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{64,   100, 0, 0,  16,  4'hf, 0};
    vecs[1] = '{61,   60,  0, 0,  16,  4'h1, 0};
    vecs[2] = '{0,    100, 0, 0,  0,   4'h0, 1};
    vecs[3] = '{3000, 100, 0, 0,  0,   4'h0, 1};
    vecs[4] = '{100,  100, 5, 20, 25,  4'hf, 0};
    vecs[5] = '{2048, 100, 0, 0,  512, 4'hf, 0};
    vecs[6] = '{2049, 100, 0, 0,  0,   4'h0, 1};
    vecs[7] = '{1,    50,  0, 0,  1,   4'h1, 0};
    vecs[8] = '{7,    100, 0, 0,  2,   4'h7, 0};

    #1 reset_n = 1'b0;
    #1 check("reset_outputs", outs_ones(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_packet(vecs[i].size, vecs[i].pct, vecs[i].s_at, vecs[i].s_len, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_words", i), beat_q.size(), vecs[i].exp_words);
      check($sformatf("vec%0d_last_keep", i), beat_q.size() > 0 ? beat_q[$].k : 4'h0, vecs[i].exp_keep);
      check($sformatf("vec%0d_err", i), err_pulses, vecs[i].exp_err);
    end

    // start held high: after HOLD and a single IDLE cycle the next packet starts immediately
    run_packet(40, 100, 0, 0, 1'b1, "held0");
    run_packet(13, 80, 0, 0, 1'b1, "held1");
    check("held1_idle_gap", idle_n, 0);
    start = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      rs = ($urandom_range(0, 7) == 0) ? $urandom_range(2049, 4095) : $urandom_range(0, 1200);
      run_packet(rs, $urandom_range(30, 100), 0, 0, 1'b0, $sformatf("rand%0d", i));
    end

    // asynchronous reset while a data response is outstanding
    prep(400, 100, 0, 0);
    start = 1'b1;
    n = 0;
    while (!(beat_q.size() >= 3 && busy && !read_en) && n < 5000) begin
      tick();
      if (busy) start = 1'b0;
      n++;
    end
    check("abort_reached_data", beat_q.size() >= 3, 1);
    #1 reset_n = 1'b0;
    #1 check("abort_outputs", outs_ones(), 0);
    pending = 0; valid_in = 1'b0; ready_and_in = 1'b0; yumi = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    run_packet(400, 70, 0, 0, 1'b0, "after_rst");

`ifdef ETH_RX_INITIATOR_TIMEOUT_EN
    prep(64, 100, 0, 0);
    no_valid = 1;
    start = 1'b1;
    n = 0;
    while (req_q.size() == 0 && n < 50) begin
      tick();
      if (busy) start = 1'b0;
      n++;
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!error && n < 1200);
    check("wd_cycles", (n == 1024) || (n == 1025), 1);
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("wd_hold_len", n, HOLDOFF);
    check("wd_no_ack", req_q.size(), 1);
    check("wd_err_pulses", err_pulses, 1);
    check("wd_v", v, 0);
    no_valid = 0;
    pending = 0;
    $display("pkt watchdog reqs=%0d err_pulses=%0d", req_q.size(), err_pulses);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
